// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch input path: debounce FSM encoding and board timing defaults.
package switch_debouncer_pkg;

    typedef logic [1:0] db_state_t;

    localparam db_state_t STABLE_LO = 2'd0;
    localparam db_state_t WAIT_HI   = 2'd1;
    localparam db_state_t STABLE_HI = 2'd2;
    localparam db_state_t WAIT_LO   = 2'd3;

    localparam int unsigned CLK_FREQ_HZ       = 50_000_000;
    localparam int unsigned DEFAULT_DB_CYCLES = 500_000;  // 10 ms at CLK_FREQ_HZ

endpackage

// File: rtl/debounce_cell.sv
// One switch channel: synchroniser, debounce FSM with stability counter, level and edge pulses.
module debounce_cell
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_event
);

    localparam int unsigned CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_sw};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_sw    = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    // Next-cycle commit, so the top can register o_valid aligned with the pulses.
    assign o_event = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_CH raw switch pins; o_valid flags any accepted edge in the same cycle as its pulse.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_sw,
    output logic [N_CH-1:0] o_sw,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic            o_valid
);

    logic [N_CH-1:0] event_d;
    logic            valid_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_cell #(
            .DB_CYCLES  (DB_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_cell (
            .clk    (clk),
            .i_rst  (i_rst),
            .i_sw   (i_sw[i]),
            .o_sw   (o_sw[i]),
            .o_rise (o_rise[i]),
            .o_fall (o_fall[i]),
            .o_event(event_d[i])
        );
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= |event_d;
        end
    end

    assign o_valid = valid_q;

endmodule
